// File: rtl/attack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : attack_pkg
//  Purpose  : Shared types for the attack sequencer: per-player phase
//             encoding, attack class encoding, controls-word bit positions
//             and the class decode helper.
//  Ports    : (package - none)
//  Revision : 1.0 - initial release
// ============================================================================
package attack_pkg;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_WINDUP  = 2'd1,
        PH_ACTIVE  = 2'd2,
        PH_RECOVER = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        CLS_NONE    = 2'd0,
        CLS_JAB     = 2'd1,
        CLS_SPECIAL = 2'd2,
        CLS_SMASH   = 2'd3
    } class_e;

    // Controls word bit positions
    localparam int SMASH_HI    = 23;
    localparam int SMASH_LO    = 20;
    localparam int SPECIAL_BIT = 17;
    localparam int JAB_BIT     = 16;

    // Smash beats special beats jab when several buttons are down together.
    function automatic class_e decode_class(input logic [3:0] smash,
                                            input logic       special,
                                            input logic       jab);
        if (|smash) begin
            return CLS_SMASH;
        end else if (special) begin
            return CLS_SPECIAL;
        end else if (jab) begin
            return CLS_JAB;
        end
        return CLS_NONE;
    endfunction

endpackage : attack_pkg
`default_nettype wire

// File: rtl/attack_phase_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : attack_phase_fsm
//  Purpose  : One player's attack phase machine IDLE->WINDUP->ACTIVE->RECOVER
//             with class decode, controls latch, phase timer and hit flag.
//  Ports    : clk_i, rst_ni      - clock, async active-low reset
//             controls_i         - raw controls word (start request)
//             hit_accept_i       - a hit for this player is being registered
//             busy_o             - phase is not IDLE
//             contender_o        - ACTIVE and no hit landed yet
//             controls_o         - controls word latched at attack start
//  Revision : 1.0 - initial release
// ============================================================================
module attack_phase_fsm
    import attack_pkg::*;
#(
    parameter int CNT_W          = 25,
    parameter int SMASH_WINDUP   = 8,
    parameter int SMASH_ACTIVE   = 16,
    parameter int SPECIAL_WINDUP = 4,
    parameter int SPECIAL_ACTIVE = 12,
    parameter int JAB_WINDUP     = 2,
    parameter int JAB_ACTIVE     = 6,
    parameter int RECOVERY       = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] controls_i,
    input  logic        hit_accept_i,
    output logic        busy_o,
    output logic        contender_o,
    output logic [31:0] controls_o
);

    // A phase of length P loads P-1, so P must fit in 2**CNT_W.
    localparam longint LIMIT = longint'(1) << CNT_W;

    generate
        if (CNT_W < 1 || CNT_W > 62 ||
            SMASH_WINDUP < 1   || longint'(SMASH_WINDUP)   > LIMIT ||
            SMASH_ACTIVE < 1   || longint'(SMASH_ACTIVE)   > LIMIT ||
            SPECIAL_WINDUP < 1 || longint'(SPECIAL_WINDUP) > LIMIT ||
            SPECIAL_ACTIVE < 1 || longint'(SPECIAL_ACTIVE) > LIMIT ||
            JAB_WINDUP < 1     || longint'(JAB_WINDUP)     > LIMIT ||
            JAB_ACTIVE < 1     || longint'(JAB_ACTIVE)     > LIMIT ||
            RECOVERY < 1       || longint'(RECOVERY)       > LIMIT) begin : g_bad_params
            $error("attack_phase_fsm: phase length out of range for CNT_W");
        end
    endgenerate

    function automatic logic [CNT_W-1:0] windup_load(input class_e c);
        case (c)
            CLS_SMASH:   return CNT_W'(SMASH_WINDUP - 1);
            CLS_SPECIAL: return CNT_W'(SPECIAL_WINDUP - 1);
            default:     return CNT_W'(JAB_WINDUP - 1);
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] active_load(input class_e c);
        case (c)
            CLS_SMASH:   return CNT_W'(SMASH_ACTIVE - 1);
            CLS_SPECIAL: return CNT_W'(SPECIAL_ACTIVE - 1);
            default:     return CNT_W'(JAB_ACTIVE - 1);
        endcase
    endfunction

    phase_e             phase_q,    phase_d;
    class_e             class_q,    class_d;
    logic [CNT_W-1:0]   timer_q,    timer_d;
    logic [31:0]        controls_q, controls_d;
    logic               hit_done_q, hit_done_d;
    class_e             req_class;

    assign req_class = decode_class(controls_i[SMASH_HI:SMASH_LO],
                                    controls_i[SPECIAL_BIT],
                                    controls_i[JAB_BIT]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q    <= PH_IDLE;
            class_q    <= CLS_NONE;
            timer_q    <= '0;
            controls_q <= '0;
            hit_done_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            class_q    <= class_d;
            timer_q    <= timer_d;
            controls_q <= controls_d;
            hit_done_q <= hit_done_d;
        end
    end

    always_comb begin
        phase_d    = phase_q;
        class_d    = class_q;
        timer_d    = timer_q;
        controls_d = controls_q;
        hit_done_d = hit_done_q;
        case (phase_q)
            PH_IDLE: begin
                if (req_class != CLS_NONE) begin
                    phase_d    = PH_WINDUP;
                    class_d    = req_class;
                    controls_d = controls_i;
                    timer_d    = windup_load(req_class);
                    hit_done_d = 1'b0;
                end
            end
            PH_WINDUP: begin
                if (timer_q == '0) begin
                    phase_d = PH_ACTIVE;
                    timer_d = active_load(class_q);
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            PH_ACTIVE: begin
                // A hit and natural expiry in the same cycle both lead to a
                // single RECOVER entry.
                if (hit_accept_i || timer_q == '0) begin
                    phase_d    = PH_RECOVER;
                    timer_d    = CNT_W'(RECOVERY - 1);
                    hit_done_d = hit_done_q | hit_accept_i;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            PH_RECOVER: begin
                if (timer_q == '0) begin
                    phase_d = PH_IDLE;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            default: begin
                phase_d = PH_IDLE;
            end
        endcase
    end

    assign busy_o      = (phase_q != PH_IDLE);
    assign contender_o = (phase_q == PH_ACTIVE) && !hit_done_q;
    assign controls_o  = controls_q;

endmodule : attack_phase_fsm
`default_nettype wire

// File: rtl/attack_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : attack_sequencer
//  Purpose  : Runs both players' attack phase machines and time-shares one
//             attack coprocessor between them (round-robin when contested),
//             turning coprocessor results into per-player hit reports.
//  Ports    : clock_i, reset_ni          - clock, async active-low reset
//             controlsN_i                - player controls words
//             charNpos_i / charNsize_i   - {X,Y} position, {W,H} size
//             cop_atk_pos/size_o         - routed attacker geometry
//             cop_def_pos/size_o         - routed defender geometry
//             cop_controls_o             - attacker's latched controls
//             cop_attack_i               - coprocessor result, bit0 = hit
//             hitN_o / hitN_valid_o      - landed attack word and pulse
//             busyN_o                    - player not IDLE
//             grant_o                    - {valid, sel}
//  Revision : 1.0 - initial release
// ============================================================================
module attack_sequencer
    import attack_pkg::*;
#(
    parameter int CNT_W          = 25,
    parameter int SMASH_WINDUP   = 8,
    parameter int SMASH_ACTIVE   = 16,
    parameter int SPECIAL_WINDUP = 4,
    parameter int SPECIAL_ACTIVE = 12,
    parameter int JAB_WINDUP     = 2,
    parameter int JAB_ACTIVE     = 6,
    parameter int RECOVERY       = 8
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic [31:0] controls1_i,
    input  logic [31:0] controls2_i,
    input  logic [31:0] char1pos_i,
    input  logic [31:0] char2pos_i,
    input  logic [31:0] char1size_i,
    input  logic [31:0] char2size_i,
    output logic [31:0] cop_atk_pos_o,
    output logic [31:0] cop_atk_size_o,
    output logic [31:0] cop_def_pos_o,
    output logic [31:0] cop_def_size_o,
    output logic [31:0] cop_controls_o,
    input  logic [31:0] cop_attack_i,
    output logic [31:0] hit1_o,
    output logic [31:0] hit2_o,
    output logic        hit1_valid_o,
    output logic        hit2_valid_o,
    output logic        busy1_o,
    output logic        busy2_o,
    output logic [1:0]  grant_o
);

    logic        contend1, contend2;
    logic [31:0] latched1, latched2;
    logic        accept1,  accept2;
    logic        grant_valid, grant_sel;

    logic        rr_q;
    logic        tag_valid_q, tag_sel_q;
    logic [31:0] atk_pos_q, atk_size_q, def_pos_q, def_size_q, cop_ctl_q;
    logic [31:0] hit1_q, hit2_q;
    logic        hit1_valid_q, hit2_valid_q;

    attack_phase_fsm #(
        .CNT_W(CNT_W), .SMASH_WINDUP(SMASH_WINDUP), .SMASH_ACTIVE(SMASH_ACTIVE),
        .SPECIAL_WINDUP(SPECIAL_WINDUP), .SPECIAL_ACTIVE(SPECIAL_ACTIVE),
        .JAB_WINDUP(JAB_WINDUP), .JAB_ACTIVE(JAB_ACTIVE), .RECOVERY(RECOVERY)
    ) u_fsm1 (
        .clk_i(clock_i), .rst_ni(reset_ni), .controls_i(controls1_i),
        .hit_accept_i(accept1), .busy_o(busy1_o), .contender_o(contend1),
        .controls_o(latched1)
    );

    attack_phase_fsm #(
        .CNT_W(CNT_W), .SMASH_WINDUP(SMASH_WINDUP), .SMASH_ACTIVE(SMASH_ACTIVE),
        .SPECIAL_WINDUP(SPECIAL_WINDUP), .SPECIAL_ACTIVE(SPECIAL_ACTIVE),
        .JAB_WINDUP(JAB_WINDUP), .JAB_ACTIVE(JAB_ACTIVE), .RECOVERY(RECOVERY)
    ) u_fsm2 (
        .clk_i(clock_i), .rst_ni(reset_ni), .controls_i(controls2_i),
        .hit_accept_i(accept2), .busy_o(busy2_o), .contender_o(contend2),
        .controls_o(latched2)
    );

    // sel = 0 routes player 1, sel = 1 routes player 2.
    always_comb begin
        grant_valid = contend1 | contend2;
        grant_sel   = (contend1 && contend2) ? rr_q : contend2;
    end

    // The result in flight belongs to the player granted last cycle; it only
    // counts if that player is still able to land a hit this attack.
    assign accept1 = tag_valid_q && !tag_sel_q && cop_attack_i[0] && contend1;
    assign accept2 = tag_valid_q &&  tag_sel_q && cop_attack_i[0] && contend2;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr_q         <= 1'b0;
            tag_valid_q  <= 1'b0;
            tag_sel_q    <= 1'b0;
            atk_pos_q    <= '0;
            atk_size_q   <= '0;
            def_pos_q    <= '0;
            def_size_q   <= '0;
            cop_ctl_q    <= '0;
            hit1_q       <= '0;
            hit2_q       <= '0;
            hit1_valid_q <= 1'b0;
            hit2_valid_q <= 1'b0;
        end else begin
            if (grant_valid) begin
                atk_pos_q  <= grant_sel ? char2pos_i  : char1pos_i;
                atk_size_q <= grant_sel ? char2size_i : char1size_i;
                def_pos_q  <= grant_sel ? char1pos_i  : char2pos_i;
                def_size_q <= grant_sel ? char1size_i : char2size_i;
                cop_ctl_q  <= grant_sel ? latched2    : latched1;
            end
            if (contend1 && contend2) begin
                rr_q <= ~rr_q;
            end
            tag_valid_q  <= grant_valid;
            tag_sel_q    <= grant_sel;
            hit1_valid_q <= accept1;
            hit2_valid_q <= accept2;
            if (accept1) begin
                hit1_q <= cop_attack_i;
            end
            if (accept2) begin
                hit2_q <= cop_attack_i;
            end
        end
    end

    assign grant_o        = {grant_valid, grant_sel};
    assign cop_atk_pos_o  = atk_pos_q;
    assign cop_atk_size_o = atk_size_q;
    assign cop_def_pos_o  = def_pos_q;
    assign cop_def_size_o = def_size_q;
    assign cop_controls_o = cop_ctl_q;
    assign hit1_o         = hit1_q;
    assign hit2_o         = hit2_q;
    assign hit1_valid_o   = hit1_valid_q;
    assign hit2_valid_o   = hit2_valid_q;

endmodule : attack_sequencer
`default_nettype wire

// File: tb/tb_attack_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_attack_sequencer
//  Purpose  : Self-checking bench for attack_sequencer: directed scenarios
//             plus a randomized run, compared against a cycle-level
//             behavioural model built from phase lengths and hit rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_attack_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] c1, c2, p1, p2, s1, s2, cop;
    logic [31:0] atk_pos, atk_size, def_pos, def_size, cop_ctl, hit1, hit2;
    logic        hv1, hv2, busy1, busy2;
    logic [1:0]  grant;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    attack_sequencer dut (
        .clock_i(clk), .reset_ni(rst_n),
        .controls1_i(c1), .controls2_i(c2),
        .char1pos_i(p1), .char2pos_i(p2),
        .char1size_i(s1), .char2size_i(s2),
        .cop_atk_pos_o(atk_pos), .cop_atk_size_o(atk_size),
        .cop_def_pos_o(def_pos), .cop_def_size_o(def_size),
        .cop_controls_o(cop_ctl), .cop_attack_i(cop),
        .hit1_o(hit1), .hit2_o(hit2),
        .hit1_valid_o(hv1), .hit2_valid_o(hv2),
        .busy1_o(busy1), .busy2_o(busy2), .grant_o(grant)
    );

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 windup, 2 active, 3 recover; rem = cycles left in phase
    int          m_ph[2];
    int          m_rem[2];
    logic [31:0] m_ctl[2];
    bit          m_hd[2];
    bit          m_rr, m_tv, m_ts;
    logic [31:0] m_ap, m_as, m_dp, m_ds, m_cc;
    logic [31:0] m_hit[2];
    bit          m_hv[2];

    function automatic int wind_len(input logic [31:0] c);
        if (c[23:20] != 4'd0) return 8;
        if (c[17]) return 4;
        if (c[16]) return 2;
        return 0;
    endfunction

    function automatic int act_len(input logic [31:0] c);
        if (c[23:20] != 4'd0) return 16;
        if (c[17]) return 12;
        return 6;
    endfunction

    function automatic bit contends(input int p);
        return (m_ph[p] == 2) && !m_hd[p];
    endfunction

    function automatic logic [1:0] m_grant();
        if (contends(0) && contends(1)) return {1'b1, m_rr};
        if (contends(0)) return 2'b10;
        if (contends(1)) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_ph[p] = 0; m_rem[p] = 0; m_ctl[p] = '0;
            m_hd[p] = 0; m_hit[p] = '0; m_hv[p] = 0;
        end
        m_rr = 0; m_tv = 0; m_ts = 0;
        m_ap = '0; m_as = '0; m_dp = '0; m_ds = '0; m_cc = '0;
    endtask

    // One rising edge with the inputs currently driven.
    task automatic model_clock();
        logic [1:0]  g;
        bit          both;
        bit          acc[2];
        logic [31:0] ci[2];
        logic [31:0] pos[2];
        logic [31:0] siz[2];
        ci[0] = c1;  ci[1] = c2;
        pos[0] = p1; pos[1] = p2;
        siz[0] = s1; siz[1] = s2;
        g    = m_grant();
        both = contends(0) && contends(1);
        for (int p = 0; p < 2; p++)
            acc[p] = m_tv && (int'(m_ts) == p) && cop[0] && contends(p);
        if (g[1]) begin
            m_ap = pos[g[0]];  m_as = siz[g[0]];
            m_dp = pos[!g[0]]; m_ds = siz[!g[0]];
            m_cc = m_ctl[g[0]];
        end
        m_tv = g[1];
        m_ts = g[0];
        if (both) m_rr = !m_rr;
        for (int p = 0; p < 2; p++) begin
            m_hv[p] = acc[p];
            if (acc[p]) m_hit[p] = cop;
            case (m_ph[p])
                0: if (wind_len(ci[p]) > 0) begin
                    m_ph[p] = 1; m_rem[p] = wind_len(ci[p]);
                    m_ctl[p] = ci[p]; m_hd[p] = 0;
                end
                1: if (m_rem[p] == 1) begin
                    m_ph[p] = 2; m_rem[p] = act_len(m_ctl[p]);
                end else m_rem[p]--;
                2: if (acc[p] || m_rem[p] == 1) begin
                    m_ph[p] = 3; m_rem[p] = 8;
                    if (acc[p]) m_hd[p] = 1;
                end else m_rem[p]--;
                default: if (m_rem[p] == 1) m_ph[p] = 0; else m_rem[p]--;
            endcase
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("busy1",        32'(busy1),   32'(m_ph[0] != 0));
        chk("busy2",        32'(busy2),   32'(m_ph[1] != 0));
        chk("grant",        32'(grant),   32'(m_grant()));
        chk("cop_atk_pos",  atk_pos,      m_ap);
        chk("cop_atk_size", atk_size,     m_as);
        chk("cop_def_pos",  def_pos,      m_dp);
        chk("cop_def_size", def_size,     m_ds);
        chk("cop_controls", cop_ctl,      m_cc);
        chk("hit1",         hit1,         m_hit[0]);
        chk("hit2",         hit2,         m_hit[1]);
        chk("hit1_valid",   32'(hv1),     32'(m_hv[0]));
        chk("hit2_valid",   32'(hv2),     32'(m_hv[1]));
    endtask

    // Mid-cycle: release reset if held, then compare this cycle's outputs.
    task automatic tick();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
    endtask

    // Drive this cycle's inputs and advance the model over the next edge.
    task automatic drive(input logic [31:0] n1, input logic [31:0] n2, input logic [31:0] ncop);
        c1 = n1; c2 = n2; cop = ncop;
        p1 = $urandom; p2 = $urandom; s1 = $urandom; s2 = $urandom;
        model_clock();
    endtask

    task automatic assert_reset_now();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_busy2", 32'(busy2), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_hit1",  hit1,       32'd0);
        chk("rst_atkpos", atk_pos,   32'd0);
        model_reset();
    endtask

    task automatic do_reset();
        @(negedge clk);
        assert_reset_now();
        @(posedge clk);
    endtask

    function automatic logic [31:0] nohit();
        return $urandom & 32'hFFFF_FFFE;
    endfunction

    function automatic logic [31:0] noise();
        return $urandom & 32'hFF0C_FFFF;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        c1 = '0; c2 = '0; p1 = '0; p2 = '0; s1 = '0; s2 = '0; cop = '0;
        model_reset();
        repeat (2) @(posedge clk);

        // 1: lone smash from player 1
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k >= 9 && k <= 24) chk("t1_grant", 32'(grant), 32'h2);
            if (k == 8)  chk("t1_grant_pre", 32'(grant), 32'h0);
            if (k == 32) chk("t1_busy_last", 32'(busy1), 32'd1);
            if (k == 33) chk("t1_busy_done", 32'(busy1), 32'd0);
            drive(k == 0 ? 32'h0040_0000 : noise(), 32'h0, nohit());
        end

        // 2: overlapping jabs, contested grants alternate
        do_reset();
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k >= 3 && k <= 8)
                chk("t2_grant", 32'(grant), (k % 2 == 0) ? 32'h3 : 32'h2);
            drive(k == 0 ? 32'h0001_0000 : 32'h0, k == 0 ? 32'h0001_0000 : 32'h0, nohit());
        end

        // 3: player 1 special lands a hit while player 2 also active
        do_reset();
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 10) begin
                chk("t3_hv1",  32'(hv1), 32'd1);
                chk("t3_hit1", hit1,     32'h0000_0401);
            end
            if (k == 11) chk("t3_hv1_once", 32'(hv1), 32'd0);
            if (k >= 10 && k <= 17) chk("t3_grant_p2", 32'(grant), 32'h3);
            drive(k == 0 ? 32'h0002_0000 : 32'h0,
                  k == 1 ? 32'h0002_0000 : 32'h0,
                  k == 9 ? 32'h0000_0401 : nohit());
        end

        // 4: result arrives one cycle after ACTIVE expired - dropped
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 9) chk("t4_grant_off", 32'(grant), 32'h0);
            if (k == 10) begin
                chk("t4_hv1",  32'(hv1), 32'd0);
                chk("t4_hit1", hit1,     32'h0000_0401);
            end
            drive(k == 0 ? 32'h0001_0000 : 32'h0, 32'h0,
                  k == 9 ? 32'h0000_0003 : nohit());
        end

        // 5: reset during player 2 windup, button held throughout
        do_reset();
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 3) chk("t5_busy2_pre", 32'(busy2), 32'd1);
            if (k == 4) chk("t5_busy2_rst", 32'(busy2), 32'd0);
            if (k == 5) chk("t5_busy2_restart", 32'(busy2), 32'd1);
            drive(32'h0, 32'h0080_0000, nohit());
            if (k == 3) assert_reset_now();
        end

        // 6: smash+jab together selects smash; re-press while busy ignored
        do_reset();
        for (int k = 0; k < 36; k++) begin
            tick();
            if (k == 8)  chk("t6_grant_pre", 32'(grant), 32'h0);
            if (k == 9)  chk("t6_grant",     32'(grant), 32'h2);
            if (k == 10) chk("t6_cop_ctl",   cop_ctl,    32'h0081_0000);
            if (k == 32) chk("t6_busy_last", 32'(busy1), 32'd1);
            if (k == 33) chk("t6_busy_done", 32'(busy1), 32'd0);
            drive(k == 0 ? 32'h0081_0000 : (k == 5 ? 32'h0001_0000 : 32'h0),
                  32'h0, nohit());
        end

        // Randomized play with trades, late results and a mid-run reset
        for (int k = 0; k < 400; k++) begin
            logic [31:0] r1, r2, rc;
            tick();
            r1 = ($urandom_range(0, 9) == 0) ? ($urandom & 32'h00F3_0000) : noise();
            r2 = ($urandom_range(0, 9) == 0) ? ($urandom & 32'h00F3_0000) : noise();
            rc = ($urandom_range(0, 2) == 0) ? ($urandom | 32'h1) : nohit();
            drive(r1, r2, rc);
            if (k == 200) do_reset();
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            drive(32'h0, 32'h0, nohit());
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_attack_sequencer
`default_nettype wire
